inst_fetch_queue: RTL

Instruction fetch front end feeding the control decoder. Owns the PC, issues word fetches to instruction memory, and buffers returned instruction words in an in-order queue. Presents one instruction per handshake to the decode stage, and flushes on jump/branch redirects from the next-PC logic. Halts issue on syscall.

---
 rtl/inst_fetch_queue.sv | 112 +++++++++++
 1 files changed

// File: rtl/inst_fetch_queue.sv
// Instruction fetch front end: owns the PC, issues word fetches and queues returned words in order.
// Define IFQ_BYPASS_EN to forward a response straight to decode when the queue is empty.
module inst_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [31:0]   r_pc;
    logic [31:0]   r_q_word [DEPTH];
    logic [31:0]   r_q_pc   [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_discard;

    logic [CW-1:0] w_live;
    logic [CW:0]   w_used;
    logic          w_credit;
    logic          w_grant;
    logic          w_drop;
    logic          w_bypass;
    logic          w_push;
    logic          w_pop_q;
    logic [31:0]   w_rsp_pc;
    logic [31:0]   w_head_word;
    logic [31:0]   w_head_pc;

    // Live (non-discarded) fetches are the most recent grants, so the oldest one sits w_live words behind r_pc.
    assign w_live   = r_outstanding - r_discard;
    assign w_used   = {1'b0, r_count} + {1'b0, w_live};
    assign w_credit = w_used < (CW+1)'(DEPTH);
    assign w_rsp_pc = r_pc - (32'(w_live) << 2);

    assign imem_req  = !rst && !halt && !redirect && w_credit;
    assign imem_addr = r_pc;
    assign w_grant   = imem_req && imem_gnt;
    assign w_drop    = redirect || (r_discard != '0);

    assign w_head_word = r_q_word[r_rd_ptr];
    assign w_head_pc   = r_q_pc[r_rd_ptr];
    assign w_pop_q     = (r_count != '0) && inst_ready;

`ifdef IFQ_BYPASS_EN
    assign w_bypass   = (r_count == '0) && (r_discard == '0) && imem_rvalid && !redirect;
    assign inst_valid = (r_count != '0) || w_bypass;
    assign inst       = w_bypass ? imem_rdata : w_head_word;
    assign inst_pc    = w_bypass ? w_rsp_pc   : w_head_pc;
`else
    assign w_bypass   = 1'b0;
    assign inst_valid = (r_count != '0);
    assign inst       = w_head_word;
    assign inst_pc    = w_head_pc;
`endif

    assign w_push = imem_rvalid && !w_drop && !(w_bypass && inst_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
            r_outstanding <= '0;
            r_discard     <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_q_word[i] <= '0;
                r_q_pc[i]   <= '0;
            end
        end else begin
            if (redirect) begin
                // Everything still in flight after this cycle's response becomes garbage.
                r_pc      <= {redirect_pc[31:2], 2'b00};
                r_rd_ptr  <= '0;
                r_wr_ptr  <= '0;
                r_count   <= '0;
                r_discard <= r_outstanding - CW'(imem_rvalid);
            end else begin
                if (w_grant)
                    r_pc <= r_pc + 32'd4;
                if (w_push) begin
                    r_q_word[r_wr_ptr] <= imem_rdata;
                    r_q_pc[r_wr_ptr]   <= w_rsp_pc;
                    r_wr_ptr           <= r_wr_ptr + 1'b1;
                end
                if (w_pop_q)
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                r_count <= r_count + CW'(w_push) - CW'(w_pop_q);
                if (imem_rvalid && (r_discard != '0))
                    r_discard <= r_discard - 1'b1;
            end
            r_outstanding <= r_outstanding + CW'(w_grant) - CW'(imem_rvalid);
        end
    end
endmodule
